// File: rtl/rv_pkg.sv
// Shared constants for the execute stage: ALU op codes, operand-B selects,
// branch funct3 codes and the EX FSM state type.
package rv_pkg;

  localparam int unsigned XLEN_DEF = 32;

  localparam logic [3:0] ALU_ADD   = 4'd0;
  localparam logic [3:0] ALU_SUB   = 4'd1;
  localparam logic [3:0] ALU_SLL   = 4'd2;
  localparam logic [3:0] ALU_SLT   = 4'd3;
  localparam logic [3:0] ALU_SLTU  = 4'd4;
  localparam logic [3:0] ALU_XOR   = 4'd5;
  localparam logic [3:0] ALU_SRL   = 4'd6;
  localparam logic [3:0] ALU_SRA   = 4'd7;
  localparam logic [3:0] ALU_OR    = 4'd8;
  localparam logic [3:0] ALU_AND   = 4'd9;
  localparam logic [3:0] ALU_PASSB = 4'd10;

  localparam logic [2:0] SRCB_RS2   = 3'd0;
  localparam logic [2:0] SRCB_IMM   = 3'd1;
  localparam logic [2:0] SRCB_UPPER = 3'd2;
  localparam logic [2:0] SRCB_FOUR  = 3'd3;

  localparam logic [2:0] F3_BEQ  = 3'd0;
  localparam logic [2:0] F3_BNE  = 3'd1;
  localparam logic [2:0] F3_BLT  = 3'd4;
  localparam logic [2:0] F3_BGE  = 3'd5;
  localparam logic [2:0] F3_BLTU = 3'd6;
  localparam logic [2:0] F3_BGEU = 3'd7;

  typedef enum logic {StRun, StSquash} ex_state_e;

endpackage

// File: rtl/ex_alu.sv
// Combinational ALU plus branch comparator. Branch compares use their own
// operand pair so they stay independent of the ALU source selects.
module ex_alu
  import rv_pkg::*;
#(
  parameter int unsigned XLEN = XLEN_DEF
) (
  input  logic [3:0]      op_i,
  input  logic [XLEN-1:0] a_i,
  input  logic [XLEN-1:0] b_i,
  input  logic [XLEN-1:0] cmp_a_i,
  input  logic [XLEN-1:0] cmp_b_i,
  input  logic [2:0]      funct3_i,
  output logic [XLEN-1:0] result_o,
  output logic            taken_o
);

  logic [4:0] shamt;
  logic       eq, lt, ltu;

  assign shamt = b_i[4:0];

  always_comb begin
    result_o = '0;
    case (op_i)
      ALU_ADD:   result_o = a_i + b_i;
      ALU_SUB:   result_o = a_i - b_i;
      ALU_SLL:   result_o = a_i << shamt;
      ALU_SLT:   result_o = {{(XLEN-1){1'b0}}, $signed(a_i) < $signed(b_i)};
      ALU_SLTU:  result_o = {{(XLEN-1){1'b0}}, a_i < b_i};
      ALU_XOR:   result_o = a_i ^ b_i;
      ALU_SRL:   result_o = a_i >> shamt;
      ALU_SRA:   result_o = $unsigned($signed(a_i) >>> shamt);
      ALU_OR:    result_o = a_i | b_i;
      ALU_AND:   result_o = a_i & b_i;
      ALU_PASSB: result_o = b_i;
      default:   result_o = '0;
    endcase
  end

  assign eq  = (cmp_a_i == cmp_b_i);
  assign lt  = ($signed(cmp_a_i) < $signed(cmp_b_i));
  assign ltu = (cmp_a_i < cmp_b_i);

  always_comb begin
    taken_o = 1'b0;
    case (funct3_i)
      F3_BEQ:  taken_o = eq;
      F3_BNE:  taken_o = !eq;
      F3_BLT:  taken_o = lt;
      F3_BGE:  taken_o = !lt;
      F3_BLTU: taken_o = ltu;
      F3_BGEU: taken_o = !ltu;
      default: taken_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/ex_stage.sv
// Execute stage with EX/MEM register, branch/jump resolution and a squash FSM
// that drops the wrong-path instructions already fetched behind a redirect.
module ex_stage
  import rv_pkg::*;
#(
  parameter int unsigned XLEN         = XLEN_DEF,
  parameter int unsigned SQUASH_DEPTH = 2
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] PC,
  input  logic [XLEN-1:0] rs1val,
  input  logic [XLEN-1:0] rs2val,
  input  logic [XLEN-1:0] LoadStoreOrjalAddress,
  input  logic [XLEN-1:0] auipcOrlui,
  input  logic [3:0]      ALUControl,
  input  logic            ALUSourceA,
  input  logic [2:0]      ALUSourceB,
  input  logic [2:0]      funct3,
  input  logic            is_branch,
  input  logic            is_jal,
  input  logic            is_jalr,
  input  logic [4:0]      rd,
  input  logic            RegWrite_in,
  input  logic            DmemREB_in,
  input  logic            DmemWEB_in,
  input  logic            Dmem1ALUOUT_in,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] ALUResult,
  output logic [XLEN-1:0] StoreData,
  output logic [4:0]      rd_out,
  output logic            RegWrite,
  output logic            DmemREB,
  output logic            DmemWEB,
  output logic            Dmem1ALUOUT,
  output logic            PCsel,
  output logic [XLEN-1:0] JumporBranch
);

  localparam int unsigned CntW = (SQUASH_DEPTH < 1) ? 1 : $clog2(SQUASH_DEPTH + 1);

  ex_state_e       state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;

  logic            out_valid_q, out_valid_d;
  logic [XLEN-1:0] result_q, store_q;
  logic [4:0]      rd_q;
  logic            regwrite_q, reb_q, web_q, d1_q;
  logic            pcsel_q, pcsel_d;
  logic [XLEN-1:0] target_q;

  logic [XLEN-1:0] op_a, op_b, alu_res, link, target, jalr_sum;
  logic            br_taken, redirect, accept, keep;

  assign op_a = ALUSourceA ? PC : rs1val;

  always_comb begin
    op_b = '0;
    case (ALUSourceB)
      SRCB_RS2:   op_b = rs2val;
      SRCB_IMM:   op_b = LoadStoreOrjalAddress;
      SRCB_UPPER: op_b = auipcOrlui;
      SRCB_FOUR:  op_b = XLEN'(4);
      default:    op_b = '0;
    endcase
  end

  ex_alu #(
    .XLEN(XLEN)
  ) u_alu (
    .op_i     (ALUControl),
    .a_i      (op_a),
    .b_i      (op_b),
    .cmp_a_i  (rs1val),
    .cmp_b_i  (rs2val),
    .funct3_i (funct3),
    .result_o (alu_res),
    .taken_o  (br_taken)
  );

  assign link     = PC + XLEN'(4);
  assign jalr_sum = rs1val + LoadStoreOrjalAddress;
  assign target   = is_jalr ? {jalr_sum[XLEN-1:1], 1'b0} : PC + LoadStoreOrjalAddress;
  assign redirect = is_jal || is_jalr || (is_branch && br_taken);

  assign in_ready = !out_valid_q || out_ready;
  assign accept   = in_valid && in_ready;
  // Anything accepted while squashing is wrong-path and leaves no trace.
  assign keep     = accept && (state_q == StRun);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StRun: begin
        if (keep && redirect && (SQUASH_DEPTH != 0)) begin
          state_d = StSquash;
          cnt_d   = CntW'(SQUASH_DEPTH);
        end
      end
      StSquash: begin
        if (accept) begin
          cnt_d = cnt_q - CntW'(1);
          if (cnt_q == CntW'(1)) state_d = StRun;
        end
      end
      default: state_d = StRun;
    endcase
  end

  always_comb begin
    if (keep)           out_valid_d = 1'b1;
    else if (out_ready) out_valid_d = 1'b0;
    else                out_valid_d = out_valid_q;
  end

  assign pcsel_d = keep && redirect;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q     <= StRun;
      cnt_q       <= '0;
      out_valid_q <= 1'b0;
      result_q    <= '0;
      store_q     <= '0;
      rd_q        <= '0;
      regwrite_q  <= 1'b0;
      reb_q       <= 1'b1;
      web_q       <= 1'b1;
      d1_q        <= 1'b0;
      pcsel_q     <= 1'b0;
      target_q    <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      out_valid_q <= out_valid_d;
      pcsel_q     <= pcsel_d;
      if (pcsel_d) target_q <= target;
      if (keep) begin
        result_q   <= (is_jal || is_jalr) ? link : alu_res;
        store_q    <= rs2val;
        rd_q       <= rd;
        regwrite_q <= RegWrite_in;
        reb_q      <= DmemREB_in;
        web_q      <= DmemWEB_in;
        d1_q       <= Dmem1ALUOUT_in;
      end
    end
  end

  assign out_valid    = out_valid_q;
  assign ALUResult    = result_q;
  assign StoreData    = store_q;
  assign rd_out       = rd_q;
  assign RegWrite     = regwrite_q;
  assign DmemREB      = reb_q;
  assign DmemWEB      = web_q;
  assign Dmem1ALUOUT  = d1_q;
  assign PCsel        = pcsel_q;
  assign JumporBranch = target_q;

endmodule

// File: tb/tb_ex_stage.sv
// Self-checking bench for ex_stage: scoreboard queue of expected EX/MEM
// contents plus a small reference model of the handshake and squash window.
module tb_ex_stage;

  localparam int SQ = 2;

  typedef struct {
    logic [31:0] res;
    logic [31:0] sd;
    logic [4:0]  rdv;
    logic        rw, reb, web, d1;
  } exp_t;

  logic        clk, RST;
  logic        in_valid, in_ready, out_valid, out_ready;
  logic [31:0] PC, rs1val, rs2val, imm, upper;
  logic [3:0]  ALUControl;
  logic        ALUSourceA;
  logic [2:0]  ALUSourceB, funct3;
  logic        is_branch, is_jal, is_jalr;
  logic [4:0]  rd, rd_out;
  logic        RegWrite_in, DmemREB_in, DmemWEB_in, Dmem1ALUOUT_in;
  logic [31:0] ALUResult, StoreData, JumporBranch;
  logic        RegWrite, DmemREB, DmemWEB, Dmem1ALUOUT, PCsel;

  int checks = 0;
  int errors = 0;

  exp_t        q[$];
  logic        m_valid, m_pcsel;
  logic [31:0] m_tgt;
  int          m_sq;

  ex_stage #(.XLEN(32), .SQUASH_DEPTH(SQ)) dut (
    .CLK(clk), .RST(RST), .in_valid(in_valid), .in_ready(in_ready), .PC(PC),
    .rs1val(rs1val), .rs2val(rs2val), .LoadStoreOrjalAddress(imm), .auipcOrlui(upper),
    .ALUControl(ALUControl), .ALUSourceA(ALUSourceA), .ALUSourceB(ALUSourceB),
    .funct3(funct3), .is_branch(is_branch), .is_jal(is_jal), .is_jalr(is_jalr),
    .rd(rd), .RegWrite_in(RegWrite_in), .DmemREB_in(DmemREB_in), .DmemWEB_in(DmemWEB_in),
    .Dmem1ALUOUT_in(Dmem1ALUOUT_in), .out_valid(out_valid), .out_ready(out_ready),
    .ALUResult(ALUResult), .StoreData(StoreData), .rd_out(rd_out), .RegWrite(RegWrite),
    .DmemREB(DmemREB), .DmemWEB(DmemWEB), .Dmem1ALUOUT(Dmem1ALUOUT), .PCsel(PCsel),
    .JumporBranch(JumporBranch)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] ref_alu(logic [3:0] op, logic [31:0] a, logic [31:0] b);
    case (op)
      4'd0:    return a + b;
      4'd1:    return a - b;
      4'd2:    return a << b[4:0];
      4'd3:    return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'd4:    return (a < b) ? 32'd1 : 32'd0;
      4'd5:    return a ^ b;
      4'd6:    return a >> b[4:0];
      4'd7:    return $unsigned($signed(a) >>> b[4:0]);
      4'd8:    return a | b;
      4'd9:    return a & b;
      4'd10:   return b;
      default: return 32'd0;
    endcase
  endfunction

  function automatic logic ref_taken(logic [2:0] f3, logic [31:0] a, logic [31:0] b);
    case (f3)
      3'd0:    return a == b;
      3'd1:    return a != b;
      3'd4:    return $signed(a) < $signed(b);
      3'd5:    return $signed(a) >= $signed(b);
      3'd6:    return a < b;
      3'd7:    return a >= b;
      default: return 1'b0;
    endcase
  endfunction

  task automatic model_reset();
    q.delete();
    m_valid = 1'b0;
    m_pcsel = 1'b0;
    m_tgt   = 32'd0;
    m_sq    = 0;
  endtask

  task automatic idle();
    in_valid = 0; PC = 0; rs1val = 0; rs2val = 0; imm = 0; upper = 0;
    ALUControl = 0; ALUSourceA = 0; ALUSourceB = 0; funct3 = 3'd2;
    is_branch = 0; is_jal = 0; is_jalr = 0; rd = 0;
    RegWrite_in = 0; DmemREB_in = 1; DmemWEB_in = 1; Dmem1ALUOUT_in = 0;
  endtask

  task automatic load(input logic [3:0] op, input logic sa, input logic [2:0] sb,
                      input logic [31:0] a, input logic [31:0] b, input logic [31:0] pc,
                      input logic [31:0] im, input logic [2:0] f3, input logic br,
                      input logic jl, input logic jr, input logic rw);
    in_valid = 1; ALUControl = op; ALUSourceA = sa; ALUSourceB = sb;
    rs1val = a; rs2val = b; PC = pc; imm = im; upper = $urandom;
    funct3 = f3; is_branch = br; is_jal = jl; is_jalr = jr; RegWrite_in = rw;
    rd = 5'($urandom); DmemREB_in = 1'($urandom); DmemWEB_in = 1'($urandom);
    Dmem1ALUOUT_in = 1'($urandom);
  endtask

  // One clock: predict, advance, then compare registered outputs to the model.
  task automatic step();
    logic        exp_rdy, acc, drop, tk;
    logic [31:0] a, b, tgt;
    exp_t        e;
    #1;
    exp_rdy = !m_valid || out_ready;
    checks++;
    if (in_ready !== exp_rdy) begin
      errors++;
      $display("FAIL in_ready: got %0b expected %0b", in_ready, exp_rdy);
    end
    acc  = in_valid && exp_rdy;
    drop = (m_sq != 0);
    a = ALUSourceA ? PC : rs1val;
    case (ALUSourceB)
      3'd0: b = rs2val;
      3'd1: b = imm;
      3'd2: b = upper;
      3'd3: b = 32'd4;
      default: b = 32'd0;
    endcase
    e.res = (is_jal || is_jalr) ? PC + 32'd4 : ref_alu(ALUControl, a, b);
    e.sd = rs2val; e.rdv = rd; e.rw = RegWrite_in;
    e.reb = DmemREB_in; e.web = DmemWEB_in; e.d1 = Dmem1ALUOUT_in;
    tk  = is_jal || is_jalr || (is_branch && ref_taken(funct3, rs1val, rs2val));
    tgt = is_jalr ? ((rs1val + imm) & ~32'd1) : PC + imm;
    @(posedge clk);
    if (m_valid && out_ready) void'(q.pop_front());
    if (acc && !drop) q.push_back(e);
    m_valid = (acc && !drop) ? 1'b1 : (out_ready ? 1'b0 : m_valid);
    m_pcsel = acc && !drop && tk;
    if (m_pcsel) m_tgt = tgt;
    if (acc) begin
      if (drop) m_sq--;
      else if (tk) m_sq = SQ;
    end
    #1;
    checks++;
    if (out_valid !== m_valid) begin
      errors++;
      $display("FAIL out_valid: got %0b expected %0b", out_valid, m_valid);
    end
    if (m_valid && q.size() > 0) begin
      checks++;
      if ({ALUResult, StoreData, rd_out, RegWrite, DmemREB, DmemWEB, Dmem1ALUOUT} !==
          {q[0].res, q[0].sd, q[0].rdv, q[0].rw, q[0].reb, q[0].web, q[0].d1}) begin
        errors++;
        $display("FAIL exmem: got res=%h sd=%h rd=%0d ctl=%b%b%b%b expected res=%h sd=%h rd=%0d ctl=%b%b%b%b",
                 ALUResult, StoreData, rd_out, RegWrite, DmemREB, DmemWEB, Dmem1ALUOUT,
                 q[0].res, q[0].sd, q[0].rdv, q[0].rw, q[0].reb, q[0].web, q[0].d1);
      end
    end
    checks++;
    if (PCsel !== m_pcsel || (m_pcsel && JumporBranch !== m_tgt)) begin
      errors++;
      $display("FAIL redirect: got PCsel=%0b tgt=%h expected PCsel=%0b tgt=%h",
               PCsel, JumporBranch, m_pcsel, m_tgt);
    end
  endtask

  task automatic test_reset();
    RST = 1; out_ready = 1; idle(); model_reset();
    #1;
    checks++;
    if ({out_valid, ALUResult, StoreData, rd_out, RegWrite, DmemREB, DmemWEB, Dmem1ALUOUT,
         PCsel, JumporBranch} !== {1'b0, 32'd0, 32'd0, 5'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 32'd0}) begin
      errors++;
      $display("FAIL reset_values: got v=%0b res=%h sd=%h reb=%0b web=%0b pcsel=%0b expected v=0 res=0 sd=0 reb=1 web=1 pcsel=0",
               out_valid, ALUResult, StoreData, DmemREB, DmemWEB, PCsel);
    end
    @(negedge clk); RST = 0;
  endtask

  task automatic test_alu();
    out_ready = 1;
    load(4'd0, 0, 3'd0, 32'd5, 32'd7, 32'h0, 32'h0, 3'd2, 0, 0, 0, 1); step();
    checks++;
    if (out_valid !== 1'b1 || ALUResult !== 32'd12 || PCsel !== 1'b0) begin
      errors++; $display("FAIL add: got v=%0b res=%h pcsel=%0b expected v=1 res=0000000c pcsel=0",
                         out_valid, ALUResult, PCsel);
    end
    load(4'd7, 0, 3'd1, 32'h80000000, 32'd0, 32'h0, 32'd4, 3'd2, 0, 0, 0, 1); step();
    checks++;
    if (ALUResult !== 32'hF8000000) begin
      errors++; $display("FAIL sra: got %h expected f8000000", ALUResult);
    end
    load(4'd4, 0, 3'd0, 32'd1, 32'hFFFFFFFF, 32'h0, 32'h0, 3'd2, 0, 0, 0, 1); step();
    checks++;
    if (ALUResult !== 32'd1) begin
      errors++; $display("FAIL sltu: got %h expected 00000001", ALUResult);
    end
    load(4'd3, 0, 3'd0, 32'd1, 32'hFFFFFFFF, 32'h0, 32'h0, 3'd2, 0, 0, 0, 1); step();
    checks++;
    if (ALUResult !== 32'd0) begin
      errors++; $display("FAIL slt: got %h expected 00000000", ALUResult);
    end
    load(4'd0, 1, 3'd3, 32'd0, 32'd0, 32'h200, 32'h0, 3'd2, 0, 0, 0, 1); step();
    checks++;
    if (ALUResult !== 32'h204) begin
      errors++; $display("FAIL pc_plus_four: got %h expected 00000204", ALUResult);
    end
    for (int op = 0; op < 16; op++) begin
      load(4'(op), 1'($urandom), 3'($urandom_range(0, 5)), $urandom, $urandom, $urandom,
           $urandom, 3'd2, 0, 0, 0, 1);
      step();
    end
  endtask

  task automatic test_branch();
    out_ready = 1;
    load(4'd1, 0, 3'd0, 32'd3, 32'd3, 32'h100, 32'h20, 3'd0, 1, 0, 0, 0); step();
    checks++;
    if (PCsel !== 1'b1 || JumporBranch !== 32'h120) begin
      errors++; $display("FAIL beq_redirect: got PCsel=%0b tgt=%h expected PCsel=1 tgt=00000120",
                         PCsel, JumporBranch);
    end
    // Squashed jal: its redirect must be suppressed.
    load(4'd0, 0, 3'd0, 32'd1, 32'd1, 32'h104, 32'h40, 3'd2, 0, 1, 0, 1); step();
    checks++;
    if (PCsel !== 1'b0 || out_valid !== 1'b0) begin
      errors++; $display("FAIL squash1: got PCsel=%0b v=%0b expected PCsel=0 v=0", PCsel, out_valid);
    end
    idle(); step(); step();
    load(4'd0, 0, 3'd0, 32'd8, 32'd8, 32'h108, 32'h0, 3'd2, 0, 0, 0, 1); step();
    checks++;
    if (out_valid !== 1'b0) begin
      errors++; $display("FAIL squash2: got v=%0b expected v=0", out_valid);
    end
    load(4'd0, 0, 3'd0, 32'd1, 32'd2, 32'h120, 32'h0, 3'd2, 0, 0, 0, 1); step();
    checks++;
    if (out_valid !== 1'b1 || ALUResult !== 32'd3) begin
      errors++; $display("FAIL after_squash: got v=%0b res=%h expected v=1 res=00000003",
                         out_valid, ALUResult);
    end
    load(4'd0, 0, 3'd0, 32'd4, 32'd4, 32'h300, 32'h10, 3'd1, 1, 0, 0, 0); step();
    checks++;
    if (out_valid !== 1'b1 || PCsel !== 1'b0 || RegWrite !== 1'b0) begin
      errors++; $display("FAIL bne_untaken: got v=%0b PCsel=%0b rw=%0b expected v=1 PCsel=0 rw=0",
                         out_valid, PCsel, RegWrite);
    end
    for (int f = 0; f < 8; f++) begin
      load(4'd0, 0, 3'd0, (f % 2 == 0) ? 32'hFFFFFFF0 : 32'd5, 32'd5, 32'h400, 32'h8,
           3'(f), 1, 0, 0, 0);
      step();
      idle(); step(); step();
    end
    // Drain any squash window left open by the funct3 sweep.
    for (int i = 0; i < SQ; i++) begin
      load(4'd0, 0, 3'd0, 32'd0, 32'd0, 32'h0, 32'h0, 3'd2, 0, 0, 0, 0); step();
    end
  endtask

  task automatic test_jalr();
    out_ready = 1;
    load(4'd0, 0, 3'd1, 32'h1003, 32'h0, 32'h40, 32'h4, 3'd0, 0, 0, 1, 1); step();
    checks++;
    if (PCsel !== 1'b1 || JumporBranch !== 32'h1006 || ALUResult !== 32'h44 ||
        RegWrite !== 1'b1) begin
      errors++; $display("FAIL jalr: got PCsel=%0b tgt=%h res=%h rw=%0b expected PCsel=1 tgt=00001006 res=00000044 rw=1",
                         PCsel, JumporBranch, ALUResult, RegWrite);
    end
    for (int i = 0; i < SQ; i++) begin
      load(4'd0, 0, 3'd0, 32'd9, 32'd9, 32'h0, 32'h0, 3'd2, 0, 0, 0, 1); step();
    end
  endtask

  task automatic test_stall();
    out_ready = 0; idle(); step();
    load(4'd0, 0, 3'd0, 32'd10, 32'd20, 32'h0, 32'h0, 3'd2, 0, 0, 0, 1); step();
    load(4'd1, 0, 3'd0, 32'd50, 32'd8, 32'h0, 32'h0, 3'd2, 0, 0, 0, 1);
    step(); step();
    checks++;
    if (ALUResult !== 32'd30 || in_ready !== 1'b0) begin
      errors++; $display("FAIL stall_hold: got res=%h in_ready=%0b expected res=0000001e in_ready=0",
                         ALUResult, in_ready);
    end
    out_ready = 1; step();
    checks++;
    if (ALUResult !== 32'd42 || out_valid !== 1'b1) begin
      errors++; $display("FAIL stall_release: got res=%h v=%0b expected res=0000002a v=1",
                         ALUResult, out_valid);
    end
    idle(); step();
  endtask

  task automatic test_reset_in_squash();
    out_ready = 1;
    load(4'd0, 0, 3'd0, 32'd7, 32'd7, 32'h500, 32'h10, 3'd0, 1, 0, 0, 0); step();
    load(4'd0, 0, 3'd0, 32'd1, 32'd1, 32'h504, 32'h0, 3'd2, 0, 0, 0, 1); step();
    RST = 1; #1;
    checks++;
    if ({out_valid, PCsel, ALUResult, DmemREB, DmemWEB, JumporBranch} !==
        {1'b0, 1'b0, 32'd0, 1'b1, 1'b1, 32'd0}) begin
      errors++; $display("FAIL reset_squash: got v=%0b PCsel=%0b res=%h tgt=%h expected all reset values",
                         out_valid, PCsel, ALUResult, JumporBranch);
    end
    model_reset(); idle();
    @(negedge clk); RST = 0;
    load(4'd0, 0, 3'd0, 32'd2, 32'd2, 32'h0, 32'h0, 3'd2, 0, 0, 0, 1); step();
    checks++;
    if (out_valid !== 1'b1 || ALUResult !== 32'd4) begin
      errors++; $display("FAIL post_reset: got v=%0b res=%h expected v=1 res=00000004",
                         out_valid, ALUResult);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 200; i++) begin
      out_ready = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 3) == 0) idle();
      else begin
        load(4'($urandom), 1'($urandom), 3'($urandom_range(0, 5)), $urandom, $urandom,
             $urandom, $urandom, 3'($urandom), ($urandom_range(0, 4) == 0),
             ($urandom_range(0, 9) == 0), ($urandom_range(0, 9) == 0), 1'($urandom));
      end
      step();
    end
    idle(); out_ready = 1; step();
  endtask

  initial begin
    test_reset();
    test_alu();
    test_branch();
    test_jalr();
    test_stall();
    test_reset_in_squash();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
